// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the button bank debouncer
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } btn_state_e;

  typedef enum logic {
    MODE_TOGGLE    = 1'b0,
    MODE_MOMENTARY = 1'b1
  } btn_mode_e;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one debounced button channel: synchronizer, confirm FSM,
// toggle register and press pulse
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  input  logic mode,
  input  logic clr,
  output logic stateful_button,
  output logic press_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);
  // The entry edge is the first candidate sample, so the counter tracks the rest.
  localparam logic [CW-1:0] CONFIRM_LAST =
    CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          toggle_q, toggle_d;
  logic          pulse_q, pulse_d;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= RELEASED;
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          cnt_d = '0;
          if (DIRECT) begin
            state_d = HELD;
            accept  = 1'b1;
          end else begin
            state_d = CONFIRM_PRESS;
          end
        end
      end
      CONFIRM_PRESS: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = DIRECT ? RELEASED : CONFIRM_RELEASE;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    // clear dominates a coincident press; the pulse is still reported
    toggle_d = clr ? 1'b0 : (toggle_q ^ accept);
    pulse_d  = accept;
  end

  always_comb begin
    stateful_button = toggle_q;
    if (mode == MODE_MOMENTARY) begin
      stateful_button = (state_q == HELD) || (state_q == CONFIRM_RELEASE);
    end
    press_pulse = pulse_q;
  end

endmodule

// File: rtl/button_bank_fsm.sv
// rtl/button_bank_fsm.sv - bank of N_CH independent debounced button channels
module button_bank_fsm #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  input  logic [N_CH-1:0] mode,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] stateful_button,
  output logic [N_CH-1:0] press_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .button         (button[g]),
      .mode           (mode[g]),
      .clr            (clr[g]),
      .stateful_button(stateful_button[g]),
      .press_pulse    (press_pulse[g])
    );
  end

endmodule
